// File: rtl/bitfusion_column_ctrl_pkg.sv
// Shared types and constants for the BitFusion column controller.
//   state_e       : controller FSM states
//   COL_*         : encodings driven on the col_state bus
//   BW_*          : cfg_bitwidth codes
//   SIGNAL_*      : 48-bit fusion signal patterns per operand bitwidth
//   bw_signal()   : bitwidth -> fusion signal lookup
package bitfusion_column_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCompute,
        StDrain,
        StOut,
        StClear
    } state_e;

    localparam logic [1:0] COL_IDLE      = 2'b00;
    localparam logic [1:0] COL_LOAD      = 2'b01;
    localparam logic [1:0] COL_COMPUTE   = 2'b10;
    localparam logic [1:0] COL_DRAIN_OUT = 2'b11;

    localparam logic [1:0] BW_2B      = 2'b00;
    localparam logic [1:0] BW_4B      = 2'b01;
    localparam logic [1:0] BW_8B      = 2'b10;
    localparam logic [1:0] BW_ILLEGAL = 2'b11;

    // One bit per fusion boundary: 2b fuses nothing, 8b fuses whole bricks.
    localparam logic [47:0] SIGNAL_2B = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SIGNAL_4B = 48'h5555_5555_5555;
    localparam logic [47:0] SIGNAL_8B = 48'h1111_1111_1111;

    function automatic logic [47:0] bw_signal(input logic [1:0] bw);
        logic [47:0] sig;
        sig = '0;
        case (bw)
            BW_2B:   sig = SIGNAL_2B;
            BW_4B:   sig = SIGNAL_4B;
            BW_8B:   sig = SIGNAL_8B;
            default: sig = '0;
        endcase
        return sig;
    endfunction

endpackage

// File: rtl/bitfusion_column_ctrl_if.sv
// Bus between the column controller and its environment (scheduler,
// activation buffer, column datapath and result consumer).
//   master : controller side (drives cfg_ready, cfg_err, in_ready, in_zero,
//            wbuf_we, col_*, acc_clr, out_valid, busy)
//   slave  : environment side (drives cfg_*, in_valid, out_ready)
interface bitfusion_column_ctrl_if #(
    parameter int unsigned STEP_W = 16
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_bitwidth;
    logic [3:0]        cfg_sign_x;
    logic [3:0]        cfg_sign_y;
    logic [STEP_W-1:0] cfg_steps;
    logic              cfg_err;
    logic              in_valid;
    logic              in_ready;
    logic              in_zero;
    logic              wbuf_we;
    logic [1:0]        col_state;
    logic [1:0]        col_bitwidth;
    logic [3:0]        col_sign_x;
    logic [3:0]        col_sign_y;
    logic [47:0]       col_signal;
    logic              acc_clr;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    modport master (
        input  cfg_valid, cfg_bitwidth, cfg_sign_x, cfg_sign_y, cfg_steps, in_valid, out_ready,
        output cfg_ready, cfg_err, in_ready, in_zero, wbuf_we, col_state, col_bitwidth,
               col_sign_x, col_sign_y, col_signal, acc_clr, out_valid, busy
    );

    modport slave (
        output cfg_valid, cfg_bitwidth, cfg_sign_x, cfg_sign_y, cfg_steps, in_valid, out_ready,
        input  cfg_ready, cfg_err, in_ready, in_zero, wbuf_we, col_state, col_bitwidth,
               col_sign_x, col_sign_y, col_signal, acc_clr, out_valid, busy
    );

endinterface

// File: rtl/bitfusion_column_ctrl_counter.sv
// Loadable down-counter shared by the LOAD, COMPUTE and DRAIN phases.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val (takes priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; ignored when the count is already zero
//   is_one     : count == 1, i.e. the current cycle is the last of the phase
module bitfusion_column_ctrl_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic             is_one
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_one = (count_q == Width'(1));

endmodule

// File: rtl/bitfusion_column_ctrl.sv
// Sequencer for one 16-PE BitFusion column. Accepts a job descriptor, holds
// the column configuration, times weight-load / compute / drain, gates input
// steps, presents the result with valid/ready and then clears accumulators.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset; aborts any job in flight
//   bus   : bitfusion_column_ctrl_if.master (descriptor, input-step,
//           column-config and result handshake signals)
module bitfusion_column_ctrl
    import bitfusion_column_ctrl_pkg::*;
#(
    parameter int unsigned WLOAD_CYCLES = 2,
    parameter int unsigned DRAIN_CYCLES = 20,
    parameter int unsigned STEP_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    bitfusion_column_ctrl_if.master bus
);

    localparam logic [STEP_W-1:0] WLOAD_VAL = STEP_W'(WLOAD_CYCLES);
    localparam logic [STEP_W-1:0] DRAIN_VAL = STEP_W'(DRAIN_CYCLES);

    state_e            state_q, state_d;
    logic [1:0]        bitwidth_q;
    logic [3:0]        sign_x_q, sign_y_q;
    logic [STEP_W-1:0] steps_q;
    logic [47:0]       signal_q;
    logic              cfg_err_q, cfg_err_d;
    logic              cfg_load;

    logic              cnt_load, cnt_dec, cnt_is_one;
    logic [STEP_W-1:0] cnt_val;

    bitfusion_column_ctrl_counter #(
        .Width (STEP_W)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .is_one   (cnt_is_one)
    );

    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        cfg_load  = 1'b0;
        cfg_err_d = 1'b0;
        case (state_q)
            StIdle: begin
                // cfg_ready is high here, so cfg_valid alone consumes the descriptor.
                if (bus.cfg_valid) begin
                    if (bus.cfg_bitwidth == BW_ILLEGAL) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_load = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = WLOAD_VAL;
                        state_d  = StLoad;
                    end
                end
            end
            StLoad: begin
                cnt_dec = 1'b1;
                if (cnt_is_one) begin
                    cnt_load = 1'b1;
                    if (steps_q == '0) begin
                        cnt_val = DRAIN_VAL;
                        state_d = StDrain;
                    end else begin
                        cnt_val = steps_q;
                        state_d = StCompute;
                    end
                end
            end
            StCompute: begin
                if (bus.in_valid) begin
                    cnt_dec = 1'b1;
                    if (cnt_is_one) begin
                        cnt_load = 1'b1;
                        cnt_val  = DRAIN_VAL;
                        state_d  = StDrain;
                    end
                end
            end
            StDrain: begin
                cnt_dec = 1'b1;
                if (cnt_is_one) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bitwidth_q <= '0;
            sign_x_q   <= '0;
            sign_y_q   <= '0;
            steps_q    <= '0;
            signal_q   <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= cfg_err_d;
            if (cfg_load) begin
                bitwidth_q <= bus.cfg_bitwidth;
                sign_x_q   <= bus.cfg_sign_x;
                sign_y_q   <= bus.cfg_sign_y;
                steps_q    <= bus.cfg_steps;
                // Registered with the config so it reads 0 until the first job.
                signal_q   <= bw_signal(bus.cfg_bitwidth);
            end
        end
    end

    always_comb begin
        bus.col_state = COL_IDLE;
        case (state_q)
            StIdle:    bus.col_state = COL_IDLE;
            StLoad:    bus.col_state = COL_LOAD;
            StCompute: bus.col_state = COL_COMPUTE;
            default:   bus.col_state = COL_DRAIN_OUT;
        endcase
    end

    assign bus.cfg_ready    = (state_q == StIdle);
    assign bus.cfg_err      = cfg_err_q;
    assign bus.in_ready     = (state_q == StCompute);
    // Bubble whenever no real step is being consumed during compute or drain.
    assign bus.in_zero      = ((state_q == StCompute) && !bus.in_valid) || (state_q == StDrain);
    assign bus.wbuf_we      = (state_q == StLoad);
    assign bus.col_bitwidth = bitwidth_q;
    assign bus.col_sign_x   = sign_x_q;
    assign bus.col_sign_y   = sign_y_q;
    assign bus.col_signal   = signal_q;
    assign bus.acc_clr      = (state_q == StClear);
    assign bus.out_valid    = (state_q == StOut);
    assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_bitfusion_column_ctrl.sv
module tb_bitfusion_column_ctrl;

    localparam logic [47:0] SIG_2B = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SIG_4B = 48'h5555_5555_5555;
    localparam logic [47:0] SIG_8B = 48'h1111_1111_1111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic iv_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    bitfusion_column_ctrl_if #(.STEP_W(16)) bus ();

    bitfusion_column_ctrl #(
        .WLOAD_CYCLES (2),
        .DRAIN_CYCLES (20),
        .STEP_W       (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cfg(input logic [1:0] bw, input logic [3:0] sx, input logic [3:0] sy,
                            input logic [15:0] k);
        bus.cfg_bitwidth = bw;
        bus.cfg_sign_x   = sx;
        bus.cfg_sign_y   = sy;
        bus.cfg_steps    = k;
        bus.cfg_valid    = 1'b1;
    endtask

    initial begin
        bus.cfg_valid    = 1'b0;
        bus.cfg_bitwidth = '0;
        bus.cfg_sign_x   = '0;
        bus.cfg_sign_y   = '0;
        bus.cfg_steps    = '0;
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b0;

        // Reset state
        tick(2);
        reset = 1'b0;
        #1;
        chk("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_col_state", 64'(bus.col_state), 64'd0);
        chk("rst_col_signal", 64'(bus.col_signal), 64'd0);
        chk("rst_wbuf_we", 64'(bus.wbuf_we), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_zero", 64'(bus.in_zero), 64'd0);

        // Test 1: 8b, K=3, in_valid always high
        send_cfg(2'b10, 4'hA, 4'h5, 16'd3);
        bus.in_valid = 1'b1;
        tick(1);                                   // t+1
        bus.cfg_valid = 1'b0;
        chk("t1_wbuf_we_1", 64'(bus.wbuf_we), 64'd1);
        chk("t1_state_load", 64'(bus.col_state), 64'd1);
        chk("t1_busy", 64'(bus.busy), 64'd1);
        chk("t1_cfg_ready", 64'(bus.cfg_ready), 64'd0);
        chk("t1_in_ready_load", 64'(bus.in_ready), 64'd0);
        chk("t1_col_bitwidth", 64'(bus.col_bitwidth), 64'd2);
        chk("t1_col_sign_x", 64'(bus.col_sign_x), 64'hA);
        chk("t1_col_sign_y", 64'(bus.col_sign_y), 64'h5);
        chk("t1_col_signal", 64'(bus.col_signal), 64'(SIG_8B));
        tick(1);                                   // t+2
        chk("t1_wbuf_we_2", 64'(bus.wbuf_we), 64'd1);
        tick(1);                                   // t+3
        chk("t1_wbuf_we_off", 64'(bus.wbuf_we), 64'd0);
        chk("t1_state_compute", 64'(bus.col_state), 64'd2);
        chk("t1_in_ready", 64'(bus.in_ready), 64'd1);
        chk("t1_in_zero_step", 64'(bus.in_zero), 64'd0);
        tick(2);                                   // t+5
        chk("t1_state_compute_last", 64'(bus.col_state), 64'd2);
        tick(1);                                   // t+6
        chk("t1_state_drain", 64'(bus.col_state), 64'd3);
        chk("t1_in_zero_drain", 64'(bus.in_zero), 64'd1);
        chk("t1_in_ready_drain", 64'(bus.in_ready), 64'd0);
        tick(19);                                  // t+25
        chk("t1_out_valid_early", 64'(bus.out_valid), 64'd0);
        tick(1);                                   // t+26
        chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_acc_clr_out", 64'(bus.acc_clr), 64'd0);
        bus.out_ready = 1'b1;
        tick(1);                                   // t+27
        bus.out_ready = 1'b0;
        chk("t1_acc_clr", 64'(bus.acc_clr), 64'd1);
        chk("t1_out_valid_drop", 64'(bus.out_valid), 64'd0);
        chk("t1_cfg_ready_clear", 64'(bus.cfg_ready), 64'd0);
        tick(1);                                   // t+28
        chk("t1_acc_clr_once", 64'(bus.acc_clr), 64'd0);
        chk("t1_idle_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        chk("t1_idle_busy", 64'(bus.busy), 64'd0);
        chk("t1_cfg_held", 64'(bus.col_bitwidth), 64'd2);
        bus.in_valid = 1'b0;

        // Test 2: 4b, K=4, in_valid 1,0,0,1,1,1 during compute
        send_cfg(2'b01, 4'h3, 4'hC, 16'd4);
        tick(1);                                   // t+1
        bus.cfg_valid = 1'b0;
        chk("t2_col_signal", 64'(bus.col_signal), 64'(SIG_4B));
        tick(2);                                   // t+3, first compute cycle
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = iv_pat[i];
            #1;
            chk($sformatf("t2_in_zero_%0d", i), 64'(bus.in_zero), 64'(!iv_pat[i]));
            chk($sformatf("t2_in_ready_%0d", i), 64'(bus.in_ready), 64'd1);
            tick(1);
        end                                        // t+9
        bus.in_valid = 1'b0;
        chk("t2_state_drain", 64'(bus.col_state), 64'd3);
        tick(19);                                  // t+28
        chk("t2_out_valid_early", 64'(bus.out_valid), 64'd0);
        tick(1);                                   // t+29
        chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        chk("t2_acc_clr", 64'(bus.acc_clr), 64'd1);
        tick(1);
        chk("t2_idle", 64'(bus.cfg_ready), 64'd1);

        // Test 3: illegal bitwidth
        send_cfg(2'b11, 4'hF, 4'hF, 16'd7);
        tick(1);
        bus.cfg_valid = 1'b0;
        chk("t3_cfg_err", 64'(bus.cfg_err), 64'd1);
        chk("t3_busy", 64'(bus.busy), 64'd0);
        chk("t3_wbuf_we", 64'(bus.wbuf_we), 64'd0);
        chk("t3_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        chk("t3_cfg_unchanged", 64'(bus.col_bitwidth), 64'd1);
        tick(1);
        chk("t3_cfg_err_pulse", 64'(bus.cfg_err), 64'd0);
        chk("t3_busy_2", 64'(bus.busy), 64'd0);
        chk("t3_wbuf_we_2", 64'(bus.wbuf_we), 64'd0);

        // Test 4: 2b, K=0 skips compute
        send_cfg(2'b00, 4'h1, 4'h2, 16'd0);
        tick(1);                                   // t+1
        bus.cfg_valid = 1'b0;
        chk("t4_state_load", 64'(bus.col_state), 64'd1);
        chk("t4_col_signal_load", 64'(bus.col_signal), 64'(SIG_2B));
        tick(2);                                   // t+3
        chk("t4_state_drain", 64'(bus.col_state), 64'd3);
        chk("t4_in_ready", 64'(bus.in_ready), 64'd0);
        chk("t4_col_signal_drain", 64'(bus.col_signal), 64'(SIG_2B));
        tick(19);                                  // t+22
        chk("t4_out_valid_early", 64'(bus.out_valid), 64'd0);
        tick(1);                                   // t+23
        chk("t4_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t4_col_signal_out", 64'(bus.col_signal), 64'(SIG_2B));

        // Test 5: stall in OUT for 10 cycles with a competing descriptor
        send_cfg(2'b10, 4'h9, 4'h9, 16'd5);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk($sformatf("t5_out_valid_%0d", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("t5_cfg_ready_%0d", i), 64'(bus.cfg_ready), 64'd0);
        end
        chk("t5_cfg_stable", 64'(bus.col_bitwidth), 64'd0);
        chk("t5_sign_stable", 64'(bus.col_sign_x), 64'h1);
        bus.cfg_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        chk("t5_acc_clr", 64'(bus.acc_clr), 64'd1);
        tick(1);
        chk("t5_idle", 64'(bus.busy), 64'd0);
        chk("t5_cfg_not_taken", 64'(bus.col_bitwidth), 64'd0);

        // Test 6: reset mid-compute, then a fresh job
        send_cfg(2'b10, 4'h7, 4'h6, 16'd5);
        bus.in_valid = 1'b1;
        tick(1);                                   // t+1
        bus.cfg_valid = 1'b0;
        tick(3);                                   // t+4
        chk("t6_state_compute", 64'(bus.col_state), 64'd2);
        reset = 1'b1;
        tick(1);
        chk("t6_rst_state", 64'(bus.col_state), 64'd0);
        chk("t6_rst_busy", 64'(bus.busy), 64'd0);
        chk("t6_rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        chk("t6_rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("t6_rst_in_zero", 64'(bus.in_zero), 64'd0);
        chk("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_col_bw", 64'(bus.col_bitwidth), 64'd0);
        chk("t6_rst_col_sx", 64'(bus.col_sign_x), 64'd0);
        chk("t6_rst_col_signal", 64'(bus.col_signal), 64'd0);
        reset = 1'b0;
        send_cfg(2'b01, 4'h4, 4'h8, 16'd2);
        tick(1);                                   // t+1
        bus.cfg_valid = 1'b0;
        chk("t6_new_signal", 64'(bus.col_signal), 64'(SIG_4B));
        tick(23);                                  // t+24
        chk("t6_out_valid_early", 64'(bus.out_valid), 64'd0);
        tick(1);                                   // t+25
        chk("t6_out_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        chk("t6_acc_clr", 64'(bus.acc_clr), 64'd1);
        tick(1);
        chk("t6_idle", 64'(bus.cfg_ready), 64'd1);
        bus.in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
